cplx_row_acc: RTL and testbench

CPLX_ROW_ACC -- requirements
Module: cplx_row_acc

---
 rtl/cplx_row_acc.sv | 127 ++++++++++++
 tb/tb_cplx_row_acc.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cplx_row_acc.sv
// Complex row accumulator: sums a run of sign-magnitude complex terms, saturating on
// magnitude overflow, and holds the result until downstream accepts it.
module cplx_row_acc #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_img,
  input  logic              in_ovf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_img,
  output logic              out_ovf,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_real_q, acc_real_d;
  logic [DATA_W-1:0] acc_img_q, acc_img_d;
  logic              ovf_q, ovf_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DATA_W:0]   real_sum, img_sum;

  // Returns {carry_out, sign, magnitude}; -0 operands and zero results come out as +0.
  function automatic logic [DATA_W:0] sm_add(logic [DATA_W-1:0] a, logic [DATA_W-1:0] b);
    logic [DATA_W-2:0] ma, mb, mr;
    logic [DATA_W-1:0] sum;
    logic              sa, sb, sr, ov;
    ma  = a[DATA_W-2:0];
    mb  = b[DATA_W-2:0];
    sa  = a[DATA_W-1] & (ma != '0);
    sb  = b[DATA_W-1] & (mb != '0);
    ov  = 1'b0;
    sum = '0;
    if (sa == sb) begin
      sum = {1'b0, ma} + {1'b0, mb};
      sr  = sa;
      if (sum[DATA_W-1]) begin
        mr = '1;
        ov = 1'b1;
      end else begin
        mr = sum[DATA_W-2:0];
      end
    end else if (ma >= mb) begin
      mr = ma - mb;
      sr = sa;
    end else begin
      mr = mb - ma;
      sr = sb;
    end
    if (mr == '0) sr = 1'b0;
    return {ov, sr, mr};
  endfunction

  assign real_sum = sm_add(acc_real_q, in_real);
  assign img_sum  = sm_add(acc_img_q, in_img);

  always_comb begin
    state_d    = state_q;
    acc_real_d = acc_real_q;
    acc_img_d  = acc_img_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_real_d = '0;
          acc_img_d  = '0;
          ovf_d      = 1'b0;
          cnt_d      = '0;
          len_d      = len;
          state_d    = (len == '0) ? StDone : StAcc;
        end
      end
      StAcc: begin
        if (in_valid) begin
          acc_real_d = real_sum[DATA_W-1:0];
          acc_img_d  = img_sum[DATA_W-1:0];
          ovf_d      = ovf_q | in_ovf | real_sum[DATA_W] | img_sum[DATA_W];
          cnt_d      = cnt_q + LEN_W'(1);
          if (cnt_d == len_q) state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      acc_real_q <= '0;
      acc_img_q  <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      len_q      <= '0;
    end else begin
      state_q    <= state_d;
      acc_real_q <= acc_real_d;
      acc_img_q  <= acc_img_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
    end
  end

  assign in_ready  = (state_q == StAcc);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_real  = acc_real_q;
  assign out_img   = acc_img_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_cplx_row_acc.sv
// Scoreboard bench for cplx_row_acc at DATA_W=8: an integer saturating model predicts each
// result when its terms are driven; a monitor pops and compares on the output handshake.
module tb_cplx_row_acc;
  localparam int unsigned DW = 8;
  localparam int unsigned LW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] len;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_real, in_img;
  logic          in_ovf;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_real, out_img;
  logic          out_ovf;
  logic          busy;

  cplx_row_acc #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_img(in_img),
    .in_ovf(in_ovf), .out_valid(out_valid), .out_ready(out_ready),
    .out_real(out_real), .out_img(out_img), .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int results = 0;
  int runs = 0;

  logic [16:0] sb_q[$];  // {real, img, ovf}
  logic [7:0]  tr[16];
  logic [7:0]  ti[16];
  logic        to[16];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sm2i(logic [7:0] v);
    return v[7] ? -int'(v[6:0]) : int'(v[6:0]);
  endfunction

  function automatic logic [7:0] i2sm(int v);
    int m;
    m = (v < 0) ? -v : v;
    return {(v < 0), m[6:0]};
  endfunction

  function automatic int sat_add(int a, int b, output logic ov);
    int s;
    s  = a + b;
    ov = 1'b0;
    if (s > 127) begin s = 127; ov = 1'b1; end
    if (s < -127) begin s = -127; ov = 1'b1; end
    return s;
  endfunction

  always @(negedge clk) begin
    logic [16:0] e;
    if (rst_n && out_valid && out_ready) begin
      check_eq("sb_has_entry", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check_eq("result", {15'd0, out_real, out_img, out_ovf}, {15'd0, e});
      end
      results++;
    end
  end

  task automatic send_term(input logic [7:0] r, input logic [7:0] i, input logic o,
                           input int gap);
    logic ok;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_real  = r;
    in_img   = i;
    in_ovf   = o;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_real  = $urandom();
    in_img   = $urandom();
    check_eq("accept_timeout", 32'(ok), 1);
  endtask

  // Hold out_ready low for `hold` cycles (start pulsed meanwhile), then hand the result over.
  task automatic drain(input int hold);
    logic [16:0] snap;
    logic        seen;
    seen = out_valid;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      seen = out_valid;
    end
    check_eq("valid_timeout", 32'(seen), 1);
    snap = {out_real, out_img, out_ovf};
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      start = (c == 1);
      len   = 8'd3;
      @(negedge clk);
      check_eq("stall_stable", {15'd0, out_real, out_img, out_ovf}, {15'd0, snap});
      check_eq("stall_in_ready", {31'd0, in_ready}, 0);
    end
    @(posedge clk); #1;
    start     = 1'b0;
    out_ready = 1'b1;
    start     = 1'b1;
    len       = 8'd2;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start     = 1'b0;
    @(negedge clk);
    check_eq("back_idle", {30'd0, busy, out_valid}, 0);
  endtask

  task automatic run_acc(input int n, input int max_gap, input int hold);
    int   er, ei;
    logic ov;
    logic eo;
    er = 0;
    ei = 0;
    eo = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    len   = LW'(n);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      er = sat_add(er, sm2i(tr[k]), ov);
      eo |= ov;
      ei = sat_add(ei, sm2i(ti[k]), ov);
      eo |= ov | to[k];
      send_term(tr[k], ti[k], to[k], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
    sb_q.push_back({i2sm(er), i2sm(ei), eo});
    runs++;
    @(negedge clk);
    check_eq("valid_latency", {31'd0, out_valid}, 1);
    drain(hold);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
    in_real = '0; in_img = '0; in_ovf = 1'b0; out_ready = 1'b0;
    #12;
    check_eq("reset_state", {12'd0, in_ready, out_valid, busy, out_real, out_img, out_ovf}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    tr[0] = 8'h03; ti[0] = 8'h02; to[0] = 0;
    tr[1] = 8'h81; ti[1] = 8'h04; to[1] = 0;
    tr[2] = 8'h05; ti[2] = 8'h87; to[2] = 0;
    run_acc(3, 0, 0);

    tr[0] = 8'h64; ti[0] = 8'h00; to[0] = 0;
    tr[1] = 8'h64; ti[1] = 8'h00; to[1] = 0;
    run_acc(2, 0, 0);

    tr[0] = 8'h05; ti[0] = 8'h80; to[0] = 0;
    tr[1] = 8'h85; ti[1] = 8'h00; to[1] = 0;
    tr[2] = 8'h80; ti[2] = 8'h80; to[2] = 0;
    run_acc(3, 0, 0);

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 6; k++) begin
        tr[k] = 8'($urandom());
        ti[k] = 8'($urandom());
        to[k] = 1'b0;
      end
      run_acc(6, 3, 5);
    end

    run_acc(0, 0, 2);

    tr[0] = 8'h10; ti[0] = 8'h90; to[0] = 1;
    run_acc(1, 0, 0);

    // Abort after two of four terms; nothing may reach the output.
    @(posedge clk); #1;
    start = 1'b1;
    len   = 8'd4;
    @(posedge clk); #1;
    start = 1'b0;
    send_term(8'h11, 8'h22, 1'b1, 0);
    send_term(8'h13, 8'h24, 1'b0, 1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_reset", {12'd0, in_ready, out_valid, busy, out_real, out_img, out_ovf}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    tr[0] = 8'h01; ti[0] = 8'h01; to[0] = 0;
    run_acc(1, 0, 0);

    repeat (3) @(posedge clk);
    check_eq("result_count", 32'(results), 32'(runs));
    check_eq("sb_empty", 32'(sb_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
